// File: rtl/ariane_pkg.sv
// Core configuration types and the cacheable-region lookup
// used to classify physical addresses as cacheable or not.
package ariane_pkg;

  localparam int unsigned MaxCachedRegions = 2;

  typedef struct packed {
    logic [1:0]                             NrCachedRegionRules;
    logic [MaxCachedRegions-1:0][63:0]      CachedRegionAddrBase;
    logic [MaxCachedRegions-1:0][63:0]      CachedRegionLength;
  } ariane_cfg_t;

  localparam ariane_cfg_t ArianeDefaultConfig = '{
    NrCachedRegionRules:  2'd1,
    CachedRegionAddrBase: {64'h0, 64'h0},
    CachedRegionLength:   {64'h0, 64'h8000_0000}
  };

  function automatic logic is_inside_cacheable_regions(
    input ariane_cfg_t cfg,
    input logic [63:0] addr
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(MaxCachedRegions); i++) begin
      if (i < int'(cfg.NrCachedRegionRules)) begin
        if (addr >= cfg.CachedRegionAddrBase[i] &&
            addr < (cfg.CachedRegionAddrBase[i] +
                    cfg.CachedRegionLength[i])) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/wt_cache_pkg.sv
// Shared widths, request/response bundles and the read
// controller state encoding for the write-through D-cache.
package wt_cache_pkg;

  localparam int unsigned PLEN                = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH =
    DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH    =
    PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned DCACHE_SET_ASSOC    = 8;
  localparam int unsigned CACHE_ID_WIDTH      = 3;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic                          data_req;
    logic [1:0]                    data_size;
    logic [7:0]                    data_be;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_READ,
    RD_MISS_REQ,
    RD_MISS_WAIT,
    RD_KILL_MISS,
    RD_REPLAY_REQ,
    RD_REPLAY_READ
  } rd_state_e;

endpackage

// File: rtl/wt_dcache_rd_ctrl.sv
// Read port controller: array arbitration, tag check,
// miss hand-off and data return for one load/PTW port.
module wt_dcache_rd_ctrl
  import wt_cache_pkg::*;
  import ariane_pkg::*;
#(
  parameter logic [CACHE_ID_WIDTH-1:0] RdTxId =
    CACHE_ID_WIDTH'(1),
  parameter ariane_cfg_t ArianeCfg = ArianeDefaultConfig
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cache_en_i,
  input  dcache_req_i_t                  req_port_i,
  output dcache_req_o_t                  req_port_o,
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  output logic                           miss_we_o,
  output logic [63:0]                    miss_wdata_o,
  output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
  output logic [PLEN-1:0]                miss_paddr_o,
  output logic                           miss_nc_o,
  output logic [2:0]                     miss_size_o,
  output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
  input  logic                           miss_replay_i,
  input  logic                           miss_rtrn_vld_i,
  input  logic                           wr_cl_vld_i,
  output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
  output logic                           rd_req_o,
  output logic                           rd_tag_only_o,
  input  logic                           rd_ack_i,
  input  logic [63:0]                    rd_data_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
);

  localparam int unsigned OW = DCACHE_OFFSET_WIDTH;
  localparam int unsigned IW = DCACHE_INDEX_WIDTH;

  rd_state_e                      state_q, state_d;
  logic [DCACHE_TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [DCACHE_CL_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [OW-1:0]                  off_q, off_d;
  logic [1:0]                     size_q, size_d;
  logic [DCACHE_SET_ASSOC-1:0]    vld_q, vld_d;

  logic gnt, rvalid, hit, unused_be;

  assign unused_be = ^req_port_i.data_be;
  assign hit = (|rd_hit_oh_i) & cache_en_i;

  assign req_port_o.data_gnt    = gnt;
  assign req_port_o.data_rvalid = rvalid;
  assign req_port_o.data_rdata  = rd_data_i;

  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
  assign miss_vld_bits_o = vld_q;
  assign miss_paddr_o    = {tag_q, idx_q, off_q};
  assign miss_size_o     = {1'b0, size_q};
  assign miss_id_o       = RdTxId;
  assign miss_nc_o       = ~cache_en_i |
    ~is_inside_cacheable_regions(ArianeCfg, 64'(miss_paddr_o));
  assign rd_tag_only_o   = 1'b0;

  // Array address: live core index while looking up, latched on replay
  always_comb begin
    rd_idx_o = req_port_i.address_index[IW-1:OW];
    rd_off_o = req_port_i.address_index[OW-1:0];
    rd_tag_o = tag_q;
    if (state_q == RD_REPLAY_REQ || state_q == RD_REPLAY_READ) begin
      rd_idx_o = idx_q;
      rd_off_o = off_q;
    end
    if (state_q == RD_READ) begin
      rd_tag_o = req_port_i.address_tag;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    off_d    = off_q;
    size_d   = size_q;
    vld_d    = vld_q;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    rd_req_o = 1'b0;
    miss_req_o = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (req_port_i.data_req) begin
          rd_req_o = 1'b1;
          if (rd_ack_i) begin
            gnt     = 1'b1;
            idx_d   = req_port_i.address_index[IW-1:OW];
            off_d   = req_port_i.address_index[OW-1:0];
            size_d  = req_port_i.data_size;
            state_d = RD_READ;
          end
        end
      end
      RD_READ: begin
        if (req_port_i.kill_req) begin
          rvalid  = 1'b1;
          state_d = RD_IDLE;
        end else if (req_port_i.tag_valid) begin
          tag_d = req_port_i.address_tag;
          vld_d = rd_vld_bits_i;
          if (wr_cl_vld_i) begin
            state_d = RD_REPLAY_REQ;
          end else if (hit) begin
            rvalid  = 1'b1;
            state_d = RD_IDLE;
            if (req_port_i.data_req) begin
              rd_req_o = 1'b1;
              if (rd_ack_i) begin
                gnt     = 1'b1;
                idx_d   = req_port_i.address_index[IW-1:OW];
                off_d   = req_port_i.address_index[OW-1:0];
                size_d  = req_port_i.data_size;
                state_d = RD_READ;
              end
            end
          end else begin
            state_d = RD_MISS_REQ;
          end
        end else begin
          rd_req_o = 1'b1;
        end
      end
      RD_MISS_REQ: begin
        miss_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          rvalid  = 1'b1;
          state_d = miss_ack_i ? RD_KILL_MISS : RD_IDLE;
        end else if (miss_replay_i) begin
          state_d = RD_REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = RD_MISS_WAIT;
        end
      end
      RD_MISS_WAIT: begin
        if (req_port_i.kill_req) begin
          rvalid  = 1'b1;
          state_d = miss_rtrn_vld_i ? RD_IDLE : RD_KILL_MISS;
        end else if (miss_rtrn_vld_i) begin
          rvalid  = 1'b1;
          state_d = RD_IDLE;
        end
      end
      RD_KILL_MISS: begin
        if (miss_rtrn_vld_i) begin
          state_d = RD_IDLE;
        end
      end
      RD_REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (rd_ack_i) begin
          state_d = RD_REPLAY_READ;
        end
      end
      RD_REPLAY_READ: begin
        vld_d = rd_vld_bits_i;
        if (req_port_i.kill_req || hit) begin
          rvalid  = 1'b1;
          state_d = RD_IDLE;
        end else begin
          state_d = RD_MISS_REQ;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // State and latched request registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// Scoreboard bench for the D-cache read port controller:
// expected read data queued at stimulus, popped on rvalid.
module tb_wt_dcache_rd_ctrl;
  import wt_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                           cache_en;
  dcache_req_i_t                  req;
  dcache_req_o_t                  rsp;
  logic                           miss_req, miss_ack, miss_we;
  logic [63:0]                    miss_wdata;
  logic [DCACHE_SET_ASSOC-1:0]    miss_vld;
  logic [PLEN-1:0]                miss_paddr;
  logic                           miss_nc;
  logic [2:0]                     miss_size;
  logic [CACHE_ID_WIDTH-1:0]      miss_id;
  logic                           miss_replay, miss_rtrn, wr_cl;
  logic [DCACHE_TAG_WIDTH-1:0]    rd_tag;
  logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
  logic [DCACHE_OFFSET_WIDTH-1:0] rd_off;
  logic                           rd_req, rd_tag_only, rd_ack;
  logic [63:0]                    rd_data;
  logic [DCACHE_SET_ASSOC-1:0]    rd_vld, rd_hit;

  wt_dcache_rd_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cache_en_i      (cache_en),
    .req_port_i      (req),
    .req_port_o      (rsp),
    .miss_req_o      (miss_req),
    .miss_ack_i      (miss_ack),
    .miss_we_o       (miss_we),
    .miss_wdata_o    (miss_wdata),
    .miss_vld_bits_o (miss_vld),
    .miss_paddr_o    (miss_paddr),
    .miss_nc_o       (miss_nc),
    .miss_size_o     (miss_size),
    .miss_id_o       (miss_id),
    .miss_replay_i   (miss_replay),
    .miss_rtrn_vld_i (miss_rtrn),
    .wr_cl_vld_i     (wr_cl),
    .rd_tag_o        (rd_tag),
    .rd_idx_o        (rd_idx),
    .rd_off_o        (rd_off),
    .rd_req_o        (rd_req),
    .rd_tag_only_o   (rd_tag_only),
    .rd_ack_i        (rd_ack),
    .rd_data_i       (rd_data),
    .rd_vld_bits_i   (rd_vld),
    .rd_hit_oh_i     (rd_hit)
  );

  typedef struct {
    logic        cmp;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_rv   = 0;
  int   n_exp  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic cmp, input logic [63:0] d);
    exp_t e;
    e.cmp  = cmp;
    e.data = d;
    sb.push_back(e);
    n_exp++;
  endtask

  // Every rvalid must consume exactly one scoreboard entry
  exp_t got_e;
  always @(negedge clk) begin
    if (rsp.data_rvalid) begin
      n_rv++;
      if (sb.size() == 0) begin
        check("spurious_rvalid", 64'd1, 64'd0);
      end else begin
        got_e = sb.pop_front();
        if (got_e.cmp) check("rdata", rsp.data_rdata, got_e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    req         = '0;
    miss_ack    = 1'b0;
    miss_replay = 1'b0;
    miss_rtrn   = 1'b0;
    wr_cl       = 1'b0;
    rd_ack      = 1'b0;
    rd_hit      = '0;
  endtask

  // Issue a request granted in this cycle; returns in READ
  task automatic issue(input logic [11:0] idx, input string tag);
    req.data_req      = 1'b1;
    req.address_index = idx;
    req.data_size     = 2'd3;
    rd_ack            = 1'b1;
    settle();
    check(tag, {63'd0, rsp.data_gnt}, 64'd1);
    cyc();
    req.data_req = 1'b0;
    rd_ack       = 1'b0;
  endtask

  task automatic lookup(input logic [43:0] tag,
                        input logic [7:0] hit);
    req.tag_valid   = 1'b1;
    req.address_tag = tag;
    rd_hit          = hit;
  endtask

  initial begin
    cache_en = 1'b1;
    rd_data  = '0;
    rd_vld   = '0;
    quiet();
    rst_n = 1'b0;
    cyc();
    cyc();
    settle();
    check("rst_gnt", {63'd0, rsp.data_gnt}, 64'd0);
    check("rst_rvalid", {63'd0, rsp.data_rvalid}, 64'd0);
    check("rst_rd_req", {63'd0, rd_req}, 64'd0);
    check("rst_miss_req", {63'd0, miss_req}, 64'd0);
    check("const_we", {62'd0, miss_we, rd_tag_only}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Hit
    issue(12'h040, "hit_gnt");
    lookup(44'h55, 8'h01);
    rd_data = 64'hDEAD_BEEF;
    push(1'b1, 64'hDEAD_BEEF);
    settle();
    check("hit_tag", 64'(rd_tag), 64'h55);
    check("hit_no_miss", {63'd0, miss_req}, 64'd0);
    cyc();
    quiet();
    settle();
    check("hit_idle", {63'd0, miss_req}, 64'd0);

    // Miss then refill
    issue(12'h040, "miss_gnt");
    lookup(44'h1234, 8'h00);
    rd_vld = 8'h0F;
    cyc();
    quiet();
    rd_vld = '0;
    settle();
    check("miss_req", {63'd0, miss_req}, 64'd1);
    check("miss_paddr", 64'(miss_paddr), 64'h1234_040);
    check("miss_nc", {63'd0, miss_nc}, 64'd0);
    check("miss_id", 64'(miss_id), 64'd1);
    check("miss_size", 64'(miss_size), 64'd3);
    check("miss_vld", 64'(miss_vld), 64'h0F);
    miss_ack = 1'b1;
    cyc();
    miss_ack = 1'b0;
    settle();
    check("wait_no_req", {63'd0, miss_req}, 64'd0);
    cyc();
    miss_rtrn = 1'b1;
    rd_data   = 64'hCAFE_F00D_1234_5678;
    push(1'b1, 64'hCAFE_F00D_1234_5678);
    cyc();
    quiet();

    // Cache disabled: hit vector ignored, non-cacheable miss
    cache_en = 1'b0;
    issue(12'h100, "nc_gnt");
    lookup(44'h1234, 8'h01);
    cyc();
    quiet();
    settle();
    check("nc_miss_req", {63'd0, miss_req}, 64'd1);
    check("nc_flag", {63'd0, miss_nc}, 64'd1);
    miss_ack = 1'b1;
    cyc();
    miss_ack  = 1'b0;
    miss_rtrn = 1'b1;
    rd_data   = 64'h0BAD_CAFE;
    push(1'b1, 64'h0BAD_CAFE);
    cyc();
    quiet();
    cache_en = 1'b1;

    // Kill after miss_ack, uncached address region
    issue(12'h040, "kill_gnt");
    lookup(44'h80000, 8'h00);
    cyc();
    quiet();
    settle();
    check("kill_nc_region", {63'd0, miss_nc}, 64'd1);
    miss_ack = 1'b1;
    cyc();
    miss_ack     = 1'b0;
    req.kill_req = 1'b1;
    push(1'b0, 64'd0);
    cyc();
    req.kill_req  = 1'b0;
    req.data_req  = 1'b1;
    req.address_index = 12'h200;
    rd_ack        = 1'b1;
    settle();
    check("kill_busy_gnt", {63'd0, rsp.data_gnt}, 64'd0);
    cyc();
    miss_rtrn = 1'b1;
    settle();
    check("kill_rtrn_gnt", {63'd0, rsp.data_gnt}, 64'd0);
    cyc();
    miss_rtrn = 1'b0;
    settle();
    check("kill_free_gnt", {63'd0, rsp.data_gnt}, 64'd1);
    cyc();
    req.data_req = 1'b0;
    rd_ack       = 1'b0;
    lookup(44'h9, 8'h02);
    rd_data = 64'h1111;
    push(1'b1, 64'h1111);
    cyc();
    quiet();

    // Replay requested by the miss unit
    issue(12'h3A8, "rpl_gnt");
    lookup(44'h777, 8'h00);
    cyc();
    quiet();
    miss_replay = 1'b1;
    cyc();
    miss_replay = 1'b0;
    req.address_index = 12'h000;
    settle();
    check("rpl_rd_req", {63'd0, rd_req}, 64'd1);
    check("rpl_idx", 64'({rd_idx, rd_off}), 64'h3A8);
    check("rpl_tag", 64'(rd_tag), 64'h777);
    check("rpl_no_miss", {63'd0, miss_req}, 64'd0);
    rd_ack = 1'b1;
    cyc();
    rd_ack  = 1'b0;
    rd_hit  = 8'h04;
    rd_data = 64'h2222;
    push(1'b1, 64'h2222);
    cyc();
    quiet();

    // Cacheline write collision during lookup
    issue(12'h0C4, "col_gnt");
    lookup(44'h42, 8'h01);
    wr_cl = 1'b1;
    cyc();
    quiet();
    settle();
    check("col_rd_req", {63'd0, rd_req}, 64'd1);
    check("col_idx", 64'({rd_idx, rd_off}), 64'h0C4);
    rd_ack = 1'b1;
    cyc();
    rd_ack  = 1'b0;
    rd_hit  = 8'h01;
    rd_data = 64'h3333;
    push(1'b1, 64'h3333);
    cyc();
    quiet();

    // Back-to-back hits
    issue(12'h010, "b2b_gnt_a");
    lookup(44'hA, 8'h01);
    rd_data = 64'hAAAA;
    push(1'b1, 64'hAAAA);
    req.data_req      = 1'b1;
    req.address_index = 12'h020;
    rd_ack            = 1'b1;
    settle();
    check("b2b_gnt_b", {63'd0, rsp.data_gnt}, 64'd1);
    cyc();
    req.data_req = 1'b0;
    rd_ack       = 1'b0;
    lookup(44'hB, 8'h01);
    rd_data = 64'hBBBB;
    push(1'b1, 64'hBBBB);
    cyc();
    quiet();
    settle();
    check("b2b_done", {63'd0, rsp.data_rvalid}, 64'd0);

    // Kill beats simultaneous hit, no re-grant
    issue(12'h030, "kh_gnt");
    lookup(44'hC, 8'h01);
    req.kill_req = 1'b1;
    req.data_req = 1'b1;
    rd_ack       = 1'b1;
    push(1'b0, 64'd0);
    settle();
    check("kh_no_gnt", {63'd0, rsp.data_gnt}, 64'd0);
    cyc();
    quiet();

    // Reset in MISS_WAIT
    issue(12'h050, "rst_gnt2");
    lookup(44'hD, 8'h00);
    cyc();
    quiet();
    miss_ack = 1'b1;
    cyc();
    miss_ack = 1'b0;
    rst_n    = 1'b0;
    cyc();
    settle();
    check("rst2_miss_req", {63'd0, miss_req}, 64'd0);
    check("rst2_paddr", 64'(miss_paddr), 64'd0);
    check("rst2_rd_req", {63'd0, rd_req}, 64'd0);
    rst_n     = 1'b1;
    miss_rtrn = 1'b1;
    cyc();
    miss_rtrn = 1'b0;
    cyc();
    cyc();

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("rvalid_count", 64'(n_rv), 64'(n_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
